mem_unit: RTL and testbench
===========================

MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on posedge clk.
REQ-002 Parameter DATA_W, default 16, SHALL set the word width of bus and memory.
REQ-003 Parameter ADDR_W, default 8, SHALL set the address width; memory depth SHALL be 2**ADDR_W words.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mar_write  in  1  CU strobe: load MAR from bus_in[ADDR_W-1:0]
- ram_write  in  1  CU strobe: write bus_in to mem[MAR]
- ram_to_bus  in  1  CU strobe: drive mem[MAR] on ram_out
- bus_in  in  DATA_W  shared bus value
- ram_out  out  DATA_W  read data, zero when not driving
- ld_start  in  1  begin program load (pulse)
- ld_len  in  ADDR_W+1  words to load, 0..2**ADDR_W
- ld_valid  in  1  loader word valid
- ld_data  in  DATA_W  loader word
- ld_ready  out  1  loader word accepted when ld_valid and ld_ready are both high
- ld_done  out  1  one-cycle pulse at end of load
- cpu_hold  out  1  keeps CPU/CU in reset while high
- parity_err  out  1  sticky read-parity error

Function
REQ-005 The FSM SHALL have exactly three states: HOLD, LOAD, RUN; plus a one-cycle DONE state SHALL precede RUN.
REQ-006 HOLD: cpu_hold=1, ld_ready=0; ld_start=1 SHALL move the FSM to LOAD with addr counter=0 and word counter=0.
REQ-007 In HOLD, ld_start with ld_len=0 SHALL go directly to DONE with no writes.
REQ-008 LOAD: ld_ready=1 and cpu_hold=1; each handshake SHALL write ld_data to mem[addr counter] and increment both counters.
REQ-009 When the accepted-word count reaches ld_len, the FSM SHALL leave LOAD for DONE on the next edge and SHALL deassert ld_ready in the same cycle; no extra word SHALL be accepted.
REQ-010 ld_len=2**ADDR_W SHALL fill every address; the addr counter SHALL wrap to 0 without an extra write.
REQ-011 DONE: ld_done=1 and cpu_hold=1 for exactly one cycle, then RUN.
REQ-012 RUN: cpu_hold=0 and ld_ready=0; ld_start SHALL be ignored; only rst SHALL leave RUN.
REQ-013 mar_write, ram_write and ram_to_bus SHALL be ignored in HOLD, LOAD and DONE.
REQ-014 In RUN, mar_write SHALL load MAR at the edge; ram_write SHALL write bus_in to mem[MAR] at the edge.
REQ-015 If mar_write and ram_write are both high in one cycle, the write SHALL use the old MAR.
REQ-016 ram_out SHALL be combinational mem[MAR] when ram_to_bus=1 in RUN, and 0 otherwise (zero-cycle read latency).
REQ-017 Reading an address never written since power-up SHALL return undefined data.

Reset
REQ-018 rst SHALL force: state=HOLD, MAR=0, counters=0, ld_ready=0, ld_done=0, cpu_hold=1, parity_err=0.
REQ-019 rst SHALL NOT clear memory contents.
REQ-020 rst during LOAD SHALL abort the load; words already written SHALL remain in memory.

Configuration
REQ-021 With MEM_PARITY_EN defined, each word SHALL store one extra even-parity bit, computed on every write (loader or CU).
REQ-022 With MEM_PARITY_EN defined, a RUN-state read with ram_to_bus=1 and a parity mismatch SHALL set parity_err on the next edge; parity_err SHALL stay set until rst.
REQ-023 Without MEM_PARITY_EN, no parity storage SHALL exist and parity_err SHALL be tied to 0.

Structure
REQ-024 The shared package sap_pkg SHALL hold: DATA_W/ADDR_W defaults, the mem_unit state enum, and the cs/bus_cs bit-index constants (RAM_WRITE, MAR_WRITE, RAM_TO_BUS).
REQ-025 Storage SHALL be one sub-module, ram_array, with synchronous write and asynchronous read, width DATA_W (+1 under MEM_PARITY_EN).

Verification
REQ-026 Load ld_len=3 with words 0x0A05, 0x020F, 0x0C00 and a valid gap after word 2 -> ready high only in LOAD, single ld_done pulse, cpu_hold falls the cycle after DONE, mem[0..2] match.
REQ-027 In RUN, mar_write with bus_in=0x0001 then ram_to_bus -> ram_out=0x020F in the same cycle as ram_to_bus; ram_out=0 when strobe is low.
REQ-028 In RUN, mar_write (bus_in=0x0010) together with ram_write (bus_in=0x0010), with MAR=0x05 beforehand -> mem[0x05]=0x0010 and MAR=0x10.
REQ-029 ld_len=0 -> DONE the next cycle, no memory change; ld_len=256 -> 256 writes, counter wraps, exactly 256 handshakes.
REQ-030 rst asserted after 2 of 5 words -> HOLD, cpu_hold=1, mem[0..1] retained; CU strobes during HOLD have no effect.
REQ-031 With MEM_PARITY_EN, force a flipped bit in mem[0x03] and read it in RUN -> parity_err=1 next cycle and held until rst.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared definitions for the SAP memory unit: default widths, loader FSM state
// encoding and the bit positions of the control-unit strobes in the cs vector.
package sap_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  localparam int RAM_WRITE  = 0;
  localparam int MAR_WRITE  = 1;
  localparam int RAM_TO_BUS = 2;
  localparam int CS_W       = 3;

  typedef enum logic [1:0] {
    MU_HOLD = 2'd0,
    MU_LOAD = 2'd1,
    MU_DONE = 2'd2,
    MU_RUN  = 2'd3
  } mu_state_t;

endpackage

// File: rtl/ram_array.sv
// Word storage for mem_unit: one synchronous write port and an asynchronous read port.
// Contents carry no reset, so they survive a reset of the surrounding unit.
module ram_array #(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_unit.sv
// SAP memory unit: program loader that fills RAM while holding the CPU, then
// hands RAM to the control unit. Define MEM_PARITY_EN to add a per-word even-parity bit.
//
// state | meaning
// HOLD  | CPU held in reset, waiting for ld_start
// LOAD  | accepting loader words into consecutive addresses
// DONE  | one-cycle ld_done pulse, CPU still held
// RUN   | CPU released, CU strobes own the RAM until rst
module mem_unit
  import sap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mar_write,
  input  logic              ram_write,
  input  logic              ram_to_bus,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] ram_out,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              cpu_hold,
  output logic              parity_err
);

`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  mu_state_t         r_state;
  mu_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_mar;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic [ADDR_W:0]   r_word_cnt;
  logic [ADDR_W:0]   r_len;

  logic              w_ld_ready;
  logic              w_ld_done;
  logic              w_cpu_hold;
  logic              w_run;
  logic              w_ld_hs;
  logic [CS_W-1:0]   w_cs;
  logic              w_we;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata_d;
  logic [WORD_W-1:0] w_wdata;
  logic [WORD_W-1:0] w_rdata;

  always_ff @(posedge clk) begin
    if (rst) r_state <= MU_HOLD;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_ready  = 1'b0;
    w_ld_done   = 1'b0;
    w_cpu_hold  = 1'b1;
    case (r_state)
      MU_HOLD: if (ld_start) w_state_nxt = (ld_len == '0) ? MU_DONE : MU_LOAD;
      MU_LOAD: begin
        // ready drops as soon as the count is met so no extra word slips in
        w_ld_ready = (r_word_cnt != r_len);
        if (r_word_cnt == r_len) w_state_nxt = MU_DONE;
      end
      MU_DONE: begin
        w_ld_done   = 1'b1;
        w_state_nxt = MU_RUN;
      end
      MU_RUN:  w_cpu_hold = 1'b0;
      default: w_state_nxt = MU_HOLD;
    endcase
  end

  assign ld_ready = w_ld_ready;
  assign ld_done  = w_ld_done;
  assign cpu_hold = w_cpu_hold;

  assign w_run   = (r_state == MU_RUN);
  assign w_ld_hs = w_ld_ready & ld_valid;

  always_comb begin
    w_cs             = '0;
    w_cs[RAM_WRITE]  = ram_write;
    w_cs[MAR_WRITE]  = mar_write;
    w_cs[RAM_TO_BUS] = ram_to_bus;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mar      <= '0;
      r_addr_cnt <= '0;
      r_word_cnt <= '0;
      r_len      <= '0;
    end else begin
      if (r_state == MU_HOLD && ld_start) begin
        r_addr_cnt <= '0;
        r_word_cnt <= '0;
        r_len      <= ld_len;
      end else if (w_ld_hs) begin
        r_addr_cnt <= r_addr_cnt + 1'b1;
        r_word_cnt <= r_word_cnt + 1'b1;
      end
      if (w_run && w_cs[MAR_WRITE]) r_mar <= bus_in[ADDR_W-1:0];
    end
  end

  // A write paired with mar_write lands at the MAR value before the edge
  assign w_we      = w_ld_hs | (w_run & w_cs[RAM_WRITE]);
  assign w_waddr   = w_run ? r_mar  : r_addr_cnt;
  assign w_wdata_d = w_run ? bus_in : ld_data;
  assign w_rd_en   = w_run & w_cs[RAM_TO_BUS];

`ifdef MEM_PARITY_EN
  assign w_wdata = {^w_wdata_d, w_wdata_d};
`else
  assign w_wdata = w_wdata_d;
`endif

  ram_array #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (r_mar),
    .o_rdata (w_rdata)
  );

  assign ram_out = w_rd_en ? w_rdata[DATA_W-1:0] : '0;

`ifdef MEM_PARITY_EN
  logic r_parity_err;

  always_ff @(posedge clk) begin
    if (rst)                         r_parity_err <= 1'b0;
    else if (w_rd_en && (^w_rdata))  r_parity_err <= 1'b1;
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: loader sequences, CU vector table and random
// RUN traffic against an address-indexed memory model. Parity case under MEM_PARITY_EN.
module tb_mem_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mar_write = 1'b0, ram_write = 1'b0, ram_to_bus = 1'b0;
  logic [15:0] bus_in = '0;
  logic [15:0] ram_out;
  logic        ld_start = 1'b0;
  logic [8:0]  ld_len = '0;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_data = '0;
  logic        ld_ready, ld_done, cpu_hold, parity_err;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_seen  = 0;

  logic [15:0] ref_mem [256];
  bit          ref_vld [256];
  int          ref_mar = 0;
  bit          ref_run = 0;
  logic [15:0] ld_words [256];

  typedef struct {
    bit          m;
    bit          w;
    bit          r;
    logic [15:0] bus;
    logic [15:0] exp;
  } vec_t;

  mem_unit #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .mar_write(mar_write), .ram_write(ram_write),
    .ram_to_bus(ram_to_bus), .bus_in(bus_in), .ram_out(ram_out),
    .ld_start(ld_start), .ld_len(ld_len), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .cpu_hold(cpu_hold), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_start) hs_seen <= 0;
    else if (ld_valid && ld_ready) hs_seen <= hs_seen + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    ref_mar = 0;
    ref_run = 0;
    #1;
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_parity_err", parity_err, 0);
  endtask

  // One CU cycle: strobes applied, ram_out sampled before the edge, model updated at the edge
  task automatic cu_cycle(input bit m, input bit w, input bit r, input logic [15:0] b,
                          output logic [15:0] seen);
    mar_write = m; ram_write = w; ram_to_bus = r; bus_in = b;
    #1;
    seen = ram_out;
    tick();
    if (ref_run) begin
      if (w) begin
        ref_mem[ref_mar] = b;
        ref_vld[ref_mar] = 1;
      end
      if (m) ref_mar = int'(b[7:0]);
    end
    mar_write = 0; ram_write = 0; ram_to_bus = 0;
  endtask

  task automatic read_at(input string nm, input int a, input logic [15:0] exp);
    logic [15:0] s;
    cu_cycle(1, 0, 0, 16'(a), s);
    cu_cycle(0, 0, 1, 16'h0, s);
    chk(nm, s, exp);
  endtask

  task automatic start_load(input int len);
    #1;
    chk("pre_load_ready", ld_ready, 0);
    chk("pre_load_hold", cpu_hold, 1);
    ld_len = 9'(len);
    ld_start = 1;
    tick();
    ld_start = 0;
  endtask

  task automatic feed(input int n, input int gap_after);
    int hs = 0;
    int cyc = 0;
    bit gapped = 0;
    while (hs < n && cyc < 3 * n + 20) begin
      if (gap_after > 0 && hs == gap_after && !gapped) begin
        ld_valid = 0;
        gapped = 1;
      end else begin
        ld_valid = 1;
        ld_data = ld_words[hs];
      end
      #1;
      chk("load_ready", ld_ready, 1);
      chk("load_hold", cpu_hold, 1);
      if (ld_valid && ld_ready) begin
        ref_mem[hs % 256] = ld_words[hs];
        ref_vld[hs % 256] = 1;
        hs++;
      end
      tick();
      cyc++;
    end
    if (hs < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout: got %0d handshakes required %0d", hs, n);
    end
  endtask

  // After the last word: one LOAD cycle with ready low, one DONE cycle, then RUN
  task automatic finish_load();
    ld_valid = 1;
    ld_data = 16'hFFFF;
    #1;
    chk("tail_ready", ld_ready, 0);
    chk("tail_done", ld_done, 0);
    tick();
    chk("done_pulse", ld_done, 1);
    chk("done_hold", cpu_hold, 1);
    chk("done_ready", ld_ready, 0);
    tick();
    ld_valid = 0;
    chk("run_done_low", ld_done, 0);
    chk("run_hold_low", cpu_hold, 0);
    chk("run_ready_low", ld_ready, 0);
    ref_run = 1;
  endtask

  initial begin
    vec_t        vt[$];
    logic [15:0] s;

    for (int i = 0; i < 256; i++) ref_vld[i] = 0;

    do_reset();
    #1;
    chk("rst_ram_out", ram_out, 0);

    // three-word load with a valid gap after the second word
    ld_words[0] = 16'h0A05; ld_words[1] = 16'h020F; ld_words[2] = 16'h0C00;
    start_load(3);
    feed(3, 2);
    finish_load();
    chk("hs_count_3", hs_seen, 3);

    ld_start = 1; ld_len = 9'd5;
    tick();
    ld_start = 0;
    chk("run_ignores_start_hold", cpu_hold, 0);
    chk("run_ignores_start_ready", ld_ready, 0);

    vt.push_back('{1, 0, 0, 16'h0000, 16'h0000});
    vt.push_back('{0, 0, 1, 16'h0000, 16'h0A05});
    vt.push_back('{1, 0, 0, 16'h0001, 16'h0000});
    vt.push_back('{0, 0, 1, 16'h0000, 16'h020F});
    vt.push_back('{0, 0, 0, 16'h0000, 16'h0000});
    vt.push_back('{1, 0, 0, 16'h0002, 16'h0000});
    vt.push_back('{0, 0, 1, 16'h0000, 16'h0C00});
    vt.push_back('{1, 0, 0, 16'h0010, 16'h0000});
    vt.push_back('{0, 1, 0, 16'hBEEF, 16'h0000});
    vt.push_back('{1, 0, 0, 16'h0005, 16'h0000});
    vt.push_back('{1, 1, 0, 16'h0010, 16'h0000});
    vt.push_back('{0, 0, 1, 16'h0000, 16'hBEEF});
    vt.push_back('{1, 0, 0, 16'h0005, 16'h0000});
    vt.push_back('{0, 0, 1, 16'h0000, 16'h0010});
    foreach (vt[i]) begin
      cu_cycle(vt[i].m, vt[i].w, vt[i].r, vt[i].bus, s);
      chk($sformatf("vec%0d_ram_out", i), s, vt[i].exp);
    end

    // random RUN traffic confined to 0x20..0x2F so earlier contents stay known
    for (int i = 0; i < 300; i++) begin
      int op;
      bit rd;
      bit known;
      logic [15:0] exp;
      op = $urandom_range(0, 3);
      rd = (op == 2);
      known = ref_vld[ref_mar];
      exp = ref_mem[ref_mar];
      cu_cycle(op == 0 || op == 3, op == 1 || op == 3, rd,
               (op == 0 || op == 3) ? 16'($urandom_range(32, 47)) : 16'($urandom), s);
      if (rd && known) chk("rand_read", s, exp);
      else if (!rd) chk("rand_idle_zero", s, 0);
    end
    chk("noparity_or_clean", parity_err, 0);

    // after reset: CU strobes in HOLD must not touch MAR or memory
    do_reset();
    cu_cycle(1, 1, 1, 16'h0002, s);
    chk("hold_ram_out_zero", s, 0);
    start_load(0);
    chk("len0_done_next", ld_done, 1);
    chk("len0_ready", ld_ready, 0);
    tick();
    chk("len0_run", cpu_hold, 0);
    chk("len0_done_low", ld_done, 0);
    ref_run = 1;
    cu_cycle(0, 0, 1, 16'h0, s);
    chk("mar_reset_read", s, 16'h0A05);
    read_at("keep_mem1", 1, 16'h020F);
    read_at("keep_mem2", 2, 16'h0C00);

    // abort a five-word load after two words
    do_reset();
    ld_words[0] = 16'h1111; ld_words[1] = 16'h2222;
    start_load(5);
    feed(2, 0);
    ld_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    ref_run = 0;
    ref_mar = 0;
    #1;
    chk("abort_hold", cpu_hold, 1);
    chk("abort_ready", ld_ready, 0);
    start_load(0);
    tick();
    ref_run = 1;
    read_at("abort_mem0", 0, 16'h1111);
    read_at("abort_mem1", 1, 16'h2222);
    read_at("abort_mem2", 2, 16'h0C00);

    // full-depth load
    do_reset();
    for (int i = 0; i < 256; i++) ld_words[i] = 16'($urandom);
    start_load(256);
    feed(256, 0);
    finish_load();
    chk("hs_count_256", hs_seen, 256);
    read_at("full_mem0", 0, ld_words[0]);
    read_at("full_mem255", 255, ld_words[255]);
    for (int i = 0; i < 6; i++) begin
      int a;
      a = $urandom_range(0, 255);
      read_at("full_rand", a, ld_words[a]);
    end

`ifdef MEM_PARITY_EN
    cu_cycle(1, 0, 0, 16'h0003, s);
    cu_cycle(0, 1, 0, 16'h1234, s);
    chk("par_clean", parity_err, 0);
    dut.u_ram.r_mem[3] = dut.u_ram.r_mem[3] ^ 17'h00001;
    cu_cycle(0, 0, 1, 16'h0, s);
    chk("par_set", parity_err, 1);
    tick();
    tick();
    chk("par_sticky", parity_err, 1);
    do_reset();
`else
    chk("par_tied_low", parity_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout required finish");
    $fatal(1, "timeout");
  end

endmodule
